// File: rtl/l1d_tlb_if.sv
// Bundles the L1D TLB's request/response channel and its page-walker channel.
// The TLB takes the slave view; the requester/walker side takes the master view.
interface l1d_tlb_if;
  logic        req_valid;
  logic [63:0] req_va;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_pa;
  logic        rsp_fault;
  logic        rsp_dirty;
  logic        rsp_readable;
  logic        rsp_writable;
  logic        rsp_executable;
  logic        rsp_user;
  logic        walk_req;
  logic [63:0] walk_va;
  logic        walk_rsp_valid;
  logic [63:0] walk_paddr;
  logic        walk_fault;
  logic        walk_dirty;
  logic        walk_readable;
  logic        walk_writable;
  logic        walk_executable;
  logic        walk_user;
  logic [1:0]  walk_pgsize;

  modport slave (
    input  req_valid, req_va, walk_rsp_valid, walk_paddr, walk_fault, walk_dirty,
           walk_readable, walk_writable, walk_executable, walk_user, walk_pgsize,
    output req_ready, rsp_valid, rsp_pa, rsp_fault, rsp_dirty, rsp_readable,
           rsp_writable, rsp_executable, rsp_user, walk_req, walk_va
  );

  modport master (
    output req_valid, req_va, walk_rsp_valid, walk_paddr, walk_fault, walk_dirty,
           walk_readable, walk_writable, walk_executable, walk_user, walk_pgsize,
    input  req_ready, rsp_valid, rsp_pa, rsp_fault, rsp_dirty, rsp_readable,
           rsp_writable, rsp_executable, rsp_user, walk_req, walk_va
  );
endinterface

// File: rtl/l1d_tlb.sv
// Fully-associative L1D TLB with mixed page sizes (4K/64K/2M/1G), a single
// outstanding page walk, lowest-invalid/round-robin replacement and flush.
module l1d_tlb #(
  parameter int ENTRIES = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear_tlb,
  l1d_tlb_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK, WAIT_RSP, FILL} state_t;

  state_t             r_state;
  logic [63:0]        r_va;
  logic [ENTRIES-1:0] r_valid;
  logic [26:0]        r_vpn    [ENTRIES];
  logic [43:0]        r_ppn    [ENTRIES];
  logic [1:0]         r_pgsize [ENTRIES];
  logic [4:0]         r_attr   [ENTRIES];
  logic [IW-1:0]      r_rr;
  logic               r_fill_kill;
  logic [63:12]       r_w_paddr;
  logic [1:0]         r_w_pgsize;
  logic [4:0]         r_w_attr;
  logic               r_w_fault;
  logic               r_rsp_valid;
  logic [63:0]        r_rsp_pa;
  logic               r_rsp_fault;
  logic [4:0]         r_rsp_attr;
  logic               r_walk_req;
  logic [63:0]        r_walk_va;

  logic               w_hit;
  logic [IW-1:0]      w_hit_idx;
  logic [63:0]        w_hit_pa;
  logic [IW-1:0]      w_victim;
  logic               w_use_rr;
  logic               w_unused;

  function automatic logic tag_eq(input logic [26:0] vpn, input logic [1:0] ps,
                                  input logic [26:0] va_vpn);
    case (ps)
      2'd0:    return vpn[26:18] == va_vpn[26:18];
      2'd1:    return vpn[26:9]  == va_vpn[26:9];
      2'd2:    return vpn        == va_vpn;
      default: return vpn[26:4]  == va_vpn[26:4];
    endcase
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && tag_eq(r_vpn[i], r_pgsize[i], r_va[38:12])) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  // Superpage offsets above bit 11 come from the VA, not the stored PPN.
  always_comb begin
    w_hit_pa = {8'd0, r_ppn[w_hit_idx], r_va[11:0]};
    case (r_pgsize[w_hit_idx])
      2'd0:    w_hit_pa[29:12] = r_va[29:12];
      2'd1:    w_hit_pa[20:12] = r_va[20:12];
      2'd3:    w_hit_pa[15:12] = r_va[15:12];
      default: ;
    endcase
  end

  always_comb begin
    w_victim = r_rr;
    w_use_rr = 1'b1;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!r_valid[i] && w_use_rr) begin
        w_victim = IW'(i);
        w_use_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_rr        <= '0;
      r_fill_kill <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_pa    <= '0;
      r_rsp_fault <= 1'b0;
      r_rsp_attr  <= '0;
      r_walk_req  <= 1'b0;
      r_walk_va   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_walk_req  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_va    <= bus.req_va;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit && !clear_tlb) begin
            r_rsp_valid <= 1'b1;
            r_rsp_pa    <= w_hit_pa;
            r_rsp_fault <= 1'b0;
            r_rsp_attr  <= r_attr[w_hit_idx];
            r_state     <= IDLE;
          end else begin
            r_walk_req  <= 1'b1;
            r_walk_va   <= r_va;
            r_fill_kill <= 1'b0;
            r_state     <= WALK;
          end
        end
        WALK: begin
          if (clear_tlb) r_fill_kill <= 1'b1;
          r_state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (clear_tlb) r_fill_kill <= 1'b1;
          if (bus.walk_rsp_valid) begin
            r_w_paddr  <= bus.walk_paddr[63:12];
            r_w_pgsize <= bus.walk_pgsize;
            r_w_fault  <= bus.walk_fault;
            r_w_attr   <= {bus.walk_dirty, bus.walk_readable, bus.walk_writable,
                           bus.walk_executable, bus.walk_user};
            r_state    <= FILL;
          end
        end
        FILL: begin
          r_rsp_valid <= 1'b1;
          r_rsp_fault <= r_w_fault;
          r_rsp_attr  <= r_w_fault ? '0 : r_w_attr;
          r_rsp_pa    <= r_w_fault ? '0 : {r_w_paddr, r_va[11:0]};
          if (!r_w_fault && !r_fill_kill && !clear_tlb) begin
            r_valid[w_victim]  <= 1'b1;
            r_vpn[w_victim]    <= r_va[38:12];
            r_ppn[w_victim]    <= r_w_paddr[55:12];
            r_pgsize[w_victim] <= r_w_pgsize;
            r_attr[w_victim]   <= r_w_attr;
            if (w_use_rr) r_rr <= r_rr + 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Placed after the case so a same-cycle flush overrides any fill.
      if (clear_tlb) r_valid <= '0;
    end
  end

  assign w_unused           = ^bus.walk_paddr[11:0];
  assign bus.req_ready      = (r_state == IDLE);
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_pa         = r_rsp_pa;
  assign bus.rsp_fault      = r_rsp_fault;
  assign bus.rsp_dirty      = r_rsp_attr[4];
  assign bus.rsp_readable   = r_rsp_attr[3];
  assign bus.rsp_writable   = r_rsp_attr[2];
  assign bus.rsp_executable = r_rsp_attr[1];
  assign bus.rsp_user       = r_rsp_attr[0];
  assign bus.walk_req       = r_walk_req;
  assign bus.walk_va        = r_walk_va;
endmodule

// File: tb/tb_l1d_tlb.sv
// Bench for l1d_tlb: directed scenarios plus randomized traffic checked
// against an associative-array style reference TLB with a page-table walker model.
module tb_l1d_tlb;
  localparam int ENTRIES = 8;

  logic clk = 1'b0;
  logic reset;
  logic clear_tlb;

  l1d_tlb_if tif ();

  l1d_tlb #(.ENTRIES(ENTRIES)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_tlb (clear_tlb),
    .bus       (tif)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_pa;
  logic        last_walk;

  // Reference TLB: stored VA/PA/page size/attributes per slot.
  logic        m_v  [ENTRIES];
  logic [63:0] m_va [ENTRIES];
  logic [63:0] m_pa [ENTRIES];
  logic [1:0]  m_ps [ENTRIES];
  logic [4:0]  m_at [ENTRIES];
  int          m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sh_of(input logic [1:0] ps);
    case (ps)
      2'd0:    return 30;
      2'd1:    return 21;
      2'd2:    return 12;
      default: return 16;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
  endfunction

  function automatic int model_lookup(input logic [63:0] va);
    logic [38:0] a, b;
    for (int i = 0; i < ENTRIES; i++) begin
      a = va[38:0] >> sh_of(m_ps[i]);
      b = m_va[i][38:0] >> sh_of(m_ps[i]);
      if (m_v[i] && a == b) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] model_pa(input int i, input logic [63:0] va);
    logic [63:0] mask;
    mask = (64'd1 << sh_of(m_ps[i])) - 64'd1;
    return ({8'd0, m_pa[i][55:0]} & ~mask) | (va & mask);
  endfunction

  function automatic void model_fill(input logic [63:0] va, input logic [63:0] pa,
                                     input logic [1:0] ps, input logic [4:0] at);
    int v;
    v = -1;
    for (int i = 0; i < ENTRIES; i++) if (!m_v[i] && v < 0) v = i;
    if (v < 0) begin
      v = m_rr;
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_v[v] = 1'b1; m_va[v] = va; m_pa[v] = pa; m_ps[v] = ps; m_at[v] = at;
  endfunction

  function automatic logic [4:0] obs_attr();
    return {tif.rsp_dirty, tif.rsp_readable, tif.rsp_writable, tif.rsp_executable, tif.rsp_user};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_walk(input logic v, input logic [63:0] pa, input logic [1:0] ps,
                            input logic [4:0] at, input logic flt);
    tif.walk_rsp_valid = v;
    tif.walk_paddr     = pa;
    tif.walk_pgsize    = ps;
    tif.walk_fault     = flt;
    {tif.walk_dirty, tif.walk_readable, tif.walk_writable, tif.walk_executable, tif.walk_user} = at;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", tif.rsp_valid, 1'b0);
    chk("rst_walk_req", tif.walk_req, 1'b0);
    chk("rst_rsp_pa", tif.rsp_pa, 64'd0);
    chk("rst_walk_va", tif.walk_va, 64'd0);
    chk("rst_attrs", {tif.rsp_fault, obs_attr()}, 6'd0);
    reset = 1'b1;
    model_clear();
    m_rr = 0;
    tick();
    chk("rst_req_ready", tif.req_ready, 1'b1);
  endtask

  // clr: 0 none, 1 during LOOKUP, 2 during WAIT_RSP, 3 during FILL.
  task automatic xact(input logic [63:0] va, input logic [63:0] wpa, input logic [1:0] wps,
                      input logic [4:0] wat, input logic wflt, input int clr,
                      input int noise, input int wc);
    int   hidx;
    logic exp_hit;
    logic kill;
    hidx    = model_lookup(va);
    exp_hit = (hidx >= 0) && (clr != 1);
    kill    = 1'b0;
    chk("idle_ready", tif.req_ready, 1'b1);
    tif.req_valid = 1'b1;
    tif.req_va    = va;
    tick();
    tif.req_valid = noise[0];
    tif.req_va    = ~va;
    if (clr == 1) begin
      clear_tlb = 1'b1;
      model_clear();
    end
    chk("lookup_ready", tif.req_ready, 1'b0);
    chk("lookup_quiet", {tif.rsp_valid, tif.walk_req}, 2'b00);
    tick();
    tif.req_valid = 1'b0;
    clear_tlb     = 1'b0;
    if (exp_hit) begin
      last_walk = 1'b0;
      chk("hit_rsp_valid", tif.rsp_valid, 1'b1);
      chk("hit_walk_req", tif.walk_req, 1'b0);
      chk("hit_pa", tif.rsp_pa, model_pa(hidx, va));
      chk("hit_fault", tif.rsp_fault, 1'b0);
      chk("hit_attr", obs_attr(), m_at[hidx]);
      last_pa = tif.rsp_pa;
    end else begin
      last_walk = tif.walk_req;
      chk("miss_walk_req", tif.walk_req, 1'b1);
      chk("miss_walk_va", tif.walk_va, va);
      chk("miss_rsp_valid", tif.rsp_valid, 1'b0);
      drive_walk(noise[1], ~wpa, ~wps, ~wat, ~wflt);
      tick();
      drive_walk(1'b0, '0, '0, '0, 1'b0);
      chk("walk_req_pulse", tif.walk_req, 1'b0);
      for (int i = 0; i < wc; i++) begin
        if (clr == 2 && i == 0) begin
          clear_tlb = 1'b1;
          model_clear();
          kill = 1'b1;
        end
        tick();
        clear_tlb = 1'b0;
        chk("wait_walk_va", tif.walk_va, va);
        chk("wait_quiet", {tif.rsp_valid, tif.walk_req}, 2'b00);
      end
      drive_walk(1'b1, wpa, wps, wat, wflt);
      tick();
      drive_walk(1'b0, ~wpa, ~wps, ~wat, ~wflt);
      if (clr == 3) begin
        clear_tlb = 1'b1;
        model_clear();
        kill = 1'b1;
      end
      chk("fill_early", tif.rsp_valid, 1'b0);
      tick();
      clear_tlb = 1'b0;
      drive_walk(1'b0, '0, '0, '0, 1'b0);
      chk("fill_rsp_valid", tif.rsp_valid, 1'b1);
      chk("fill_walk_req", tif.walk_req, 1'b0);
      chk("fill_fault", tif.rsp_fault, wflt);
      chk("fill_attr", obs_attr(), wflt ? 5'd0 : wat);
      if (!wflt) chk("fill_pa", tif.rsp_pa, {wpa[63:12], va[11:0]});
      last_pa = tif.rsp_pa;
      if (!wflt && !kill) model_fill(va, wpa, wps, wat);
    end
  endtask

  // Page-table model for random traffic: page size fixed per 1 GB region.
  task automatic rnd_page(output logic [63:0] va, output logic [63:0] pa, output logic [1:0] ps);
    logic [63:0] mask;
    logic [38:0] tagv;
    va        = {$urandom, $urandom};
    va[38:30] = 9'(4 + $urandom_range(0, 3));
    va[29:16] = 14'($urandom_range(0, 5));
    va[15:12] = 4'($urandom_range(0, 1));
    ps        = va[31:30];
    mask      = (64'd1 << sh_of(ps)) - 64'd1;
    tagv      = va[38:0] >> sh_of(ps);
    pa        = ((({25'd0, tagv} ^ 64'h5A5A5) << sh_of(ps)) | (va & mask))
                & 64'h00FF_FFFF_FFFF_F000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] va, pa;
    logic [1:0]  ps;
    int          k;

    reset     = 1'b0;
    clear_tlb = 1'b0;
    tif.req_valid = 1'b0;
    tif.req_va    = '0;
    drive_walk(1'b0, '0, '0, '0, 1'b0);
    tick();
    do_reset();

    xact(64'h12345678, 64'h80045000, 2'd2, 5'b11100, 1'b0, 0, 0, 2);
    chk("cold_walked", last_walk, 1'b1);
    chk("cold_pa", last_pa, 64'h80045678);
    xact(64'h12345ABC, 64'h0, 2'd2, 5'b0, 1'b0, 0, 0, 1);
    chk("same_page_hit", last_walk, 1'b0);
    chk("same_page_pa", last_pa, 64'h80045ABC);
    xact(64'h40200000, 64'h80200000, 2'd1, 5'b01010, 1'b0, 0, 0, 1);
    xact(64'h40312345, 64'h0, 2'd1, 5'b0, 1'b0, 0, 0, 1);
    chk("2mb_hit", last_walk, 1'b0);
    chk("2mb_pa", last_pa, 64'h80312345);
    xact(64'h5000, 64'h90005000, 2'd2, 5'b11111, 1'b1, 0, 0, 1);
    xact(64'h5000, 64'h90005000, 2'd2, 5'b01000, 1'b0, 0, 3, 3);
    chk("refault_walked", last_walk, 1'b1);
    xact(64'h12345678, 64'h80045000, 2'd2, 5'b11100, 1'b0, 1, 0, 1);
    chk("clear_lookup_miss", last_walk, 1'b1);
    xact(64'h7000, 64'h81007000, 2'd2, 5'b01100, 1'b0, 2, 0, 2);
    xact(64'h7000, 64'h81007000, 2'd2, 5'b01100, 1'b0, 0, 0, 1);
    chk("clear_wait_nofill", last_walk, 1'b1);
    xact(64'h9000, 64'h82009000, 2'd2, 5'b01100, 1'b0, 3, 0, 1);
    xact(64'h9000, 64'h82009000, 2'd2, 5'b01100, 1'b0, 0, 0, 1);
    chk("clear_fill_nofill", last_walk, 1'b1);

    // Reset held while a walk is outstanding.
    tif.req_valid = 1'b1;
    tif.req_va    = 64'hA000;
    tick();
    tif.req_valid = 1'b0;
    tick();
    chk("rw_walk_req", tif.walk_req, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    chk("rw_rsp_valid", tif.rsp_valid, 1'b0);
    chk("rw_walk_va", tif.walk_va, 64'd0);
    reset = 1'b1;
    model_clear();
    m_rr = 0;
    tick();
    chk("rw_ready", tif.req_ready, 1'b1);
    drive_walk(1'b1, 64'h8300A000, 2'd2, 5'b11111, 1'b0);
    tick();
    drive_walk(1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_rsp", tif.rsp_valid, 1'b0);
      tick();
    end
    xact(64'hA000, 64'h8300A000, 2'd2, 5'b11111, 1'b0, 0, 0, 1);
    chk("rw_refetch", last_walk, 1'b1);

    // Capacity: ENTRIES+1 distinct 4 KB pages from an empty TLB.
    do_reset();
    for (int i = 0; i <= ENTRIES; i++)
      xact(64'h100000 + 64'(i) * 64'h1000, 64'h400000 + 64'(i) * 64'h1000, 2'd2, 5'b01000,
           1'b0, 0, 0, 1);
    xact(64'h101234, 64'h401000, 2'd2, 5'b01000, 1'b0, 0, 0, 1);
    chk("cap_second_hit", last_walk, 1'b0);
    xact(64'h100234, 64'h400000, 2'd2, 5'b01000, 1'b0, 0, 0, 1);
    chk("cap_first_miss", last_walk, 1'b1);

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        clear_tlb = 1'b1;
        model_clear();
        tick();
        clear_tlb = 1'b0;
      end else begin
        rnd_page(va, pa, ps);
        xact(va, pa, ps, 5'($urandom), ($urandom_range(0, 7) == 0),
             (k <= 3) ? k : 0, int'($urandom), $urandom_range(1, 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l1d_tlb.md
L1D_TLB -- requirements
Module: l1d_tlb

Interface
REQ-001 Parameter: ENTRIES, default 8, number of fully-associative TLB entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
REQ-004 clear_tlb  input  1  invalidate all entries.
REQ-005 req_valid  input  1  translation request.
REQ-006 req_va  input  64  virtual address.
REQ-007 req_ready  output  1  high only in IDLE; requests with req_ready=0 are ignored.
REQ-008 rsp_valid  output  1  one-cycle pulse; translation result valid.
REQ-009 rsp_pa  output  64  physical address.
REQ-010 rsp_fault/rsp_dirty/rsp_readable/rsp_writable/rsp_executable/rsp_user  output  1 each  page attributes.
REQ-011 walk_req  output  1  one-cycle pulse to the page walker (its l1d_req).
REQ-012 walk_va  output  64  VA for the walk; held stable from the walk_req cycle until walk_rsp_valid.
REQ-013 walk_rsp_valid  input  1  walker completion pulse (its l1d_rsp_valid).
REQ-014 walk_paddr  input  64  walker physical address, already composed to 4 KB granularity.
REQ-015 walk_fault/walk_dirty/walk_readable/walk_writable/walk_executable/walk_user  input  1 each  walker attributes.
REQ-016 walk_pgsize  input  2  0 = 1 GB, 1 = 2 MB, 2 = 4 KB, 3 = 64 KB.

Function
REQ-017 Entry contents: valid, VPN = va[38:12], ppn = walk_paddr[55:12], pgsize, dirty, readable, writable, executable, user.
REQ-018 Tag compare by pgsize: 0 -> va[38:30]; 1 -> va[38:21]; 2 -> va[38:12]; 3 -> va[38:16].
REQ-019 States: IDLE, LOOKUP, WALK, WAIT_RSP, FILL.
REQ-020 IDLE: req_valid=1 latches req_va and moves to LOOKUP.
REQ-021 LOOKUP, hit: rsp_valid=1 on the next cycle with the entry's attributes and rsp_fault=0; return to IDLE. Hit latency is 2 cycles from acceptance.
REQ-022 LOOKUP, miss: go to WALK.
REQ-023 WALK: walk_req=1 for exactly one cycle, then WAIT_RSP.
REQ-024 WAIT_RSP: wait indefinitely for walk_rsp_valid, then go to FILL with the walker fields captured.
REQ-025 FILL, walk_fault=0: write the entry and pulse rsp_valid with the walker PA and attributes; return to IDLE.
REQ-026 FILL, walk_fault=1: pulse rsp_valid with rsp_fault=1 and all other attribute outputs 0; no entry is written.
REQ-027 PA on hit: rsp_pa = {8'd0, ppn, va[11:0]}, then overridden from the VA by pgsize:
- 64 KB: pa[15:12] = va[15:12].
- 2 MB: pa[20:12] = va[20:12].
- 1 GB: pa[29:12] = va[29:12].
REQ-028 Victim selection: lowest-index invalid entry if one exists; otherwise a round-robin pointer (log2 ENTRIES bits). The pointer increments, wrapping from ENTRIES-1 to 0, on every fill that used it.
REQ-029 Multiple matching entries cannot occur; the fill path only writes on a miss.
REQ-030 clear_tlb in any state clears all valid bits on the next edge and does not change the state.
REQ-031 clear_tlb during LOOKUP forces a miss.
REQ-032 clear_tlb asserted at any time from WALK through the FILL cycle suppresses that fill; the response is still delivered.
REQ-033 When clear_tlb and a fill occur in the same cycle, clear wins.
REQ-034 walk_rsp_valid outside WAIT_RSP is ignored.
REQ-035 req_valid outside IDLE is ignored; it is not queued.
REQ-036 rsp_valid and walk_req are never high in the same cycle.

Reset
REQ-037 While reset=0, on every edge: state = IDLE, all valid bits = 0, round-robin pointer = 0.
REQ-038 Outputs while reset=0: rsp_valid, walk_req = 0; rsp_pa, walk_va = 0; all rsp_* attributes = 0; req_ready = 1 from the cycle after the reset edge.
REQ-039 Reset asserted mid-walk abandons the walk; a later walk_rsp_valid is ignored because the state is IDLE.

Verification
REQ-040 Cold miss: va=0x12345678.
- Required: walk_req pulses with walk_va=0x12345678.
- Walker returns paddr=0x80045000, pgsize=2, R/W/D=1.
- Required: rsp_pa=0x80045678; entry 0 is filled.
REQ-041 Hit, same 4 KB page: va=0x12345ABC -> rsp_valid 2 cycles after acceptance, rsp_pa=0x80045ABC, no walk_req.
REQ-042 2 MB superpage:
- Fill va=0x40200000 with paddr=0x80200000, pgsize=1.
- Then va=0x40312345 -> hit, rsp_pa=0x80312345.
REQ-043 Fault: walk_fault=1 for va=0x5000 -> rsp_fault=1; a repeat of va=0x5000 issues walk_req again.
REQ-044 Capacity wrap:
- Fill ENTRIES+1 distinct 4 KB pages.
- Required: the last fill evicts entry 0; the first page then misses and the second page hits.
REQ-045 Clear mid-walk:
- Assert clear_tlb in WAIT_RSP.
- Required: the response is delivered and nothing is filled; the same VA then misses.
- Separately, reset=0 held in WAIT_RSP followed by walk_rsp_valid produces no rsp_valid.
